// File: rtl/bus_slave_responder_pkg.sv
// -----------------------------------------------------------------------------
// bus_slave_responder_pkg
// Shared definitions for the 2-bit serial bus slave: FSM state encoding,
// transfer-mode constants, default beat counts and small elaboration helpers.
// -----------------------------------------------------------------------------
package bus_slave_responder_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RWAIT = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_BEATS = DEFAULT_ADDR_WIDTH / 2;
  localparam int DEFAULT_DATA_BEATS = DEFAULT_DATA_WIDTH / 2;

  // Each beat carries two bits, MSB pair first.
  function automatic int beat_count(input int width);
    return width / 2;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_slave_mem.sv
// -----------------------------------------------------------------------------
// bus_slave_mem
// 2**ADDR_WIDTH x DATA_WIDTH register file: synchronous write, combinational
// read, asynchronous active-low clear of every word.
// Ports:
//   clk    - clock
//   reset  - async active-low clear
//   we     - write enable (one word per cycle)
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - combinational read data
// -----------------------------------------------------------------------------
module bus_slave_mem #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the words must read back as zero after reset, so the array is
  // cleared in the reset branch; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_slave_responder.sv
// -----------------------------------------------------------------------------
// bus_slave_responder
// Slave end of the 2-bit serial system bus. Deserializes address and write
// data beats into a local register file; for reads, serializes the stored
// word back onto a 2-bit return lane after READ_WAIT idle cycles.
// Ports:
//   clk                - clock, rising edge
//   reset              - async active-low reset
//   sel                - slave selected; must stay high for the whole frame
//   bus_mode           - 1 = write, 0 = read; sampled on the first address beat
//   bus_valid          - beat present on bus_data_in
//   bus_data_in        - address / write-data beat, MSB pair first
//   bus_data_out       - read-data beat, MSB pair first (0 outside RDATA)
//   bus_data_out_valid - bus_data_out carries a beat
//   slave_ready        - high in IDLE only
//   done               - one-cycle pulse at frame completion
//   err                - one-cycle pulse after a frame is aborted
// -----------------------------------------------------------------------------
module bus_slave_responder
  import bus_slave_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int READ_WAIT  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       bus_mode,
  input  logic       bus_valid,
  input  logic [1:0] bus_data_in,
  output logic [1:0] bus_data_out,
  output logic       bus_data_out_valid,
  output logic       slave_ready,
  output logic       done,
  output logic       err
);

  localparam int ADDR_BEATS = beat_count(ADDR_WIDTH);
  localparam int DATA_BEATS = beat_count(DATA_WIDTH);
  localparam int CNT_MAX    = max_int(max_int(ADDR_BEATS, DATA_BEATS), READ_WAIT);
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BEATS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BEATS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT - 1);

  state_t                  state, state_next;
  logic                    mode;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   addr_sr;
  logic [DATA_WIDTH-1:0]   data_sr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    err_q;
  logic                    beat_in;
  logic                    aborting;
  logic                    advance;
  logic                    mem_we;

  assign beat_in  = sel && bus_valid;
  // Losing sel mid-frame abandons the frame; IDLE and DONE are not mid-frame.
  assign aborting = !sel && (state != IDLE) && (state != DONE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (beat_in) begin
          if (ADDR_BEATS == 1) state_next = (bus_mode == MODE_WRITE) ? WDATA : RWAIT;
          else                 state_next = ADDR;
        end
      end
      ADDR: begin
        if (aborting) state_next = IDLE;
        else if (beat_in && cnt == ADDR_LAST)
          state_next = (mode == MODE_WRITE) ? WDATA : RWAIT;
      end
      WDATA: begin
        if (aborting)                         state_next = IDLE;
        else if (beat_in && cnt == DATA_LAST) state_next = DONE;
      end
      RWAIT: begin
        if (aborting)              state_next = IDLE;
        else if (cnt == WAIT_LAST) state_next = RDATA;
      end
      RDATA: begin
        if (aborting)              state_next = IDLE;
        else if (cnt == DATA_LAST) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter steps on captured beats in ADDR/WDATA and on every cycle in
  // RWAIT/RDATA (read beats are gap-free).
  always_comb begin
    advance = 1'b0;
    if (state == ADDR || state == WDATA)      advance = beat_in;
    else if (state == RWAIT || state == RDATA) advance = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Datapath: beat counter, shift registers, mode latch, abort flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode    <= MODE_READ;
      cnt     <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= aborting;

      // The first address beat is captured in IDLE, so ADDR starts at one.
      if (state == IDLE)            cnt <= (state_next == ADDR) ? CNT_W'(1) : '0;
      else if (state_next != state) cnt <= '0;
      else if (advance)             cnt <= cnt + 1'b1;

      if (state == IDLE && beat_in) mode <= bus_mode;

      if ((state == IDLE || state == ADDR) && beat_in)
        addr_sr <= (addr_sr << 2) | ADDR_WIDTH'(bus_data_in);

      if (state == WDATA && beat_in)
        data_sr <= (data_sr << 2) | DATA_WIDTH'(bus_data_in);
      else if (state == RWAIT && state_next == RDATA)
        data_sr <= rd_data;
      else if (state == RDATA)
        data_sr <= data_sr << 2;
    end
  end

  // The word lands during DONE, so an aborted write never reaches memory.
  assign mem_we = (state == DONE) && (mode == MODE_WRITE);

  bus_slave_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (addr_sr),
    .wdata (data_sr),
    .raddr (addr_sr),
    .rdata (rd_data)
  );

  // Outputs decode from reset-cleared state, so reset clears them immediately.
  assign slave_ready        = (state == IDLE);
  assign done               = (state == DONE);
  assign err                = err_q;
  assign bus_data_out_valid = (state == RDATA);
  assign bus_data_out       = (state == RDATA) ? data_sr[DATA_WIDTH-1 -: 2] : 2'b00;

endmodule

// File: tb/tb_bus_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_responder
// Self-checking bench for bus_slave_responder. A memory model tracks expected
// contents; read frames push expected beats to a queue that is popped as the
// DUT drives its return lane.
// -----------------------------------------------------------------------------
module tb_bus_slave_responder;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RW = 2;
  localparam int AB = AW / 2;
  localparam int DB = DW / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sel = 1'b0;
  logic       bus_mode = 1'b0;
  logic       bus_valid = 1'b0;
  logic [1:0] bus_data_in = 2'b00;
  logic [1:0] bus_data_out;
  logic       bus_data_out_valid;
  logic       slave_ready;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model [2**AW];
  logic [1:0]    exp_q [$];

  always #5 clk = ~clk;

  bus_slave_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .READ_WAIT  (RW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .sel                (sel),
    .bus_mode           (bus_mode),
    .bus_valid          (bus_valid),
    .bus_data_in        (bus_data_in),
    .bus_data_out       (bus_data_out),
    .bus_data_out_valid (bus_data_out_valid),
    .slave_ready        (slave_ready),
    .done               (done),
    .err                (err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    foreach (model[i]) model[i] = '0;
  endtask

  // Write frame; optional one-cycle gaps between every beat. bus_mode is
  // flipped after the first beat to show mid-frame changes are ignored.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input bit gaps);
    for (int i = 0; i < AB; i++) begin
      sel = 1'b1; bus_valid = 1'b1;
      bus_mode = (i == 0) ? 1'b1 : 1'b0;
      bus_data_in = 2'(addr >> (2 * (AB - 1 - i)));
      tick();
      if (gaps) begin bus_valid = 1'b0; bus_data_in = 2'b11; tick(); end
    end
    for (int i = 0; i < DB; i++) begin
      bus_valid = 1'b1;
      bus_data_in = 2'(data >> (2 * (DB - 1 - i)));
      tick();
      if (gaps && i != DB - 1) begin bus_valid = 1'b0; bus_data_in = 2'b11; tick(); end
    end
    bus_valid = 1'b0; bus_data_in = 2'b00;
    model[addr] = data;
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL write_done addr=%h: done=%b err=%b, required done=1 err=0", addr, done, err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || slave_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_done_pulse addr=%h: done=%b slave_ready=%b, required 0/1", addr, done, slave_ready);
    end
    sel = 1'b0;
  endtask

  // Read frame: expected beats pushed up front, popped as the DUT returns them.
  task automatic do_read(input logic [AW-1:0] addr, input bit gaps);
    int k;
    logic [1:0] exp_beat;
    for (int i = 0; i < DB; i++) exp_q.push_back(2'(model[addr] >> (2 * (DB - 1 - i))));
    for (int i = 0; i < AB; i++) begin
      sel = 1'b1; bus_valid = 1'b1;
      bus_mode = (i == 0) ? 1'b0 : 1'b1;
      bus_data_in = 2'(addr >> (2 * (AB - 1 - i)));
      tick();
      if (gaps && i != AB - 1) begin bus_valid = 1'b0; tick(); end
    end
    // Last address beat was captured on the edge just passed (cycle N).
    // Junk on the bus during the wait must be ignored.
    bus_valid = 1'b1; bus_data_in = 2'b11;
    checks++;
    if (bus_data_out !== 2'b00 || bus_data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_idle_lane addr=%h: out=%b valid=%b, required 00/0", addr, bus_data_out, bus_data_out_valid);
    end
    k = 0;
    while (bus_data_out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    bus_valid = 1'b0; bus_data_in = 2'b00;
    checks++;
    if (k !== RW) begin
      errors++;
      $display("FAIL read_latency addr=%h: first beat after %0d cycles, required %0d", addr, k + 1, RW + 1);
      exp_q.delete();
      sel = 1'b0;
      tick();
      return;
    end
    for (int i = 0; i < DB; i++) begin
      exp_beat = exp_q.pop_front();
      checks++;
      if (bus_data_out_valid !== 1'b1 || bus_data_out !== exp_beat) begin
        errors++;
        $display("FAIL read_beat addr=%h beat=%0d: out=%b valid=%b, required %b/1",
                 addr, i, bus_data_out, bus_data_out_valid, exp_beat);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || bus_data_out_valid !== 1'b0 || bus_data_out !== 2'b00) begin
      errors++;
      $display("FAIL read_done addr=%h: done=%b valid=%b out=%b, required 1/0/00",
               addr, done, bus_data_out_valid, bus_data_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || slave_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_done_pulse addr=%h: done=%b slave_ready=%b, required 0/1", addr, done, slave_ready);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset();
    clear_model();
    reset = 1'b0;
    #3;
    checks++;
    if (bus_data_out !== 2'b00 || bus_data_out_valid !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || slave_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: out=%b valid=%b done=%b err=%b ready=%b, required 00/0/0/0/1",
               bus_data_out, bus_data_out_valid, done, err, slave_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (slave_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: slave_ready=%b, required 1", slave_ready);
    end
  endtask

  task automatic test_write_read();
    do_write(4'hA, 8'hAA, 1'b0);
    do_read(4'hA, 1'b0);
  endtask

  task automatic test_gapped();
    do_write(4'h3, 8'hE2, 1'b1);
    do_read(4'h3, 1'b1);
  endtask

  task automatic test_abort();
    sel = 1'b1; bus_valid = 1'b1; bus_mode = 1'b1;
    for (int i = 0; i < AB; i++) begin
      bus_data_in = 2'(4'h5 >> (2 * (AB - 1 - i)));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      bus_data_in = 2'b11;
      tick();
    end
    sel = 1'b0; bus_valid = 1'b0; bus_data_in = 2'b00;
    tick();
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || slave_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_err: err=%b done=%b ready=%b, required 1/0/1", err, done, slave_ready);
    end
    tick();
    checks++;
    if (err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_err_pulse: err=%b done=%b, required 0/0", err, done);
    end
    do_read(4'h5, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_write(4'h0, 8'h3C, 1'b0);
    do_write(4'h7, 8'h81, 1'b0);
    do_read(4'h7, 1'b0);
    do_read(4'h0, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    int k;
    logic [1:0] exp_beat;
    for (int i = 0; i < DB; i++) exp_q.push_back(2'(model[4'hA] >> (2 * (DB - 1 - i))));
    sel = 1'b1; bus_valid = 1'b1; bus_mode = 1'b0;
    for (int i = 0; i < AB; i++) begin
      bus_data_in = 2'(4'hA >> (2 * (AB - 1 - i)));
      tick();
    end
    bus_valid = 1'b0; bus_data_in = 2'b00;
    k = 0;
    while (bus_data_out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    exp_beat = exp_q.pop_front();
    checks++;
    if (bus_data_out_valid !== 1'b1 || bus_data_out !== exp_beat) begin
      errors++;
      $display("FAIL midreset_first_beat: out=%b valid=%b, required %b/1", bus_data_out, bus_data_out_valid, exp_beat);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus_data_out !== 2'b00 || bus_data_out_valid !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || slave_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs: out=%b valid=%b done=%b err=%b ready=%b, required 00/0/0/0/1",
               bus_data_out, bus_data_out_valid, done, err, slave_ready);
    end
    exp_q.delete();
    clear_model();
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (slave_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release_ready: slave_ready=%b, required 1", slave_ready);
    end
    do_read(4'hA, 1'b0);
    do_read(4'h3, 1'b0);
  endtask

  task automatic test_unwritten();
    do_read(4'hF, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_gapped();
    test_abort();
    test_back_to_back();
    test_reset_mid_read();
    test_unwritten();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
